// File: rtl/pattern_rx.sv
// Receiver for the slotted on/off blink-pattern link: recovers slot timing from
// input edges, samples each slot at its midpoint and matches 32-bit windows.
module pattern_rx #(
   parameter int          SLOT_LOG2     = 21,
   parameter logic [31:0] PATTERN       = 32'h05477715,
   parameter int          TIMEOUT_SLOTS = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PIN_2,
   output logic       LED,
   output logic       LOCKED,
   output logic       BIT_VALID,
   output logic       BIT_DATA,
   output logic       MATCH,
   output logic [7:0] MATCH_CNT,
   output logic       USBPU
);

   localparam int SILENT_W = $clog2(TIMEOUT_SLOTS + 1);
   localparam logic [SLOT_LOG2-1:0] SLOT_MID    = {1'b1, {(SLOT_LOG2-1){1'b0}}};
   localparam logic [SLOT_LOG2-1:0] SLOT_MAX    = '1;
   localparam logic [SILENT_W-1:0]  SILENT_LAST = SILENT_W'(TIMEOUT_SLOTS - 1);
   localparam logic [5:0]           FILL_FULL   = 6'd32;

   typedef enum logic {HUNT, TRACK} state_t;

   state_t               state_q, state_d;
   logic                 meta_q, meta_d;
   logic                 s_q, s_d;
   logic                 s_dly_q, s_dly_d;
   logic [SLOT_LOG2-1:0] slot_q, slot_d;
   logic [SILENT_W-1:0]  silent_q, silent_d;
   logic [31:0]          shift_q, shift_d;
   logic [5:0]           fill_q, fill_d;
   logic                 locked_q, locked_d;
   logic                 led_q, led_d;
   logic                 bit_valid_q, bit_valid_d;
   logic                 bit_data_q, bit_data_d;
   logic                 match_q, match_d;
   logic [7:0]           match_cnt_q, match_cnt_d;

   logic edge_det;
   logic slot_wrap;
   logic sample_pt;

   assign edge_det  = s_q ^ s_dly_q;
   assign slot_wrap = (slot_q == SLOT_MAX);
   // An edge landing on the midpoint re-centres the slot instead of sampling it.
   assign sample_pt = !edge_det && (slot_q == SLOT_MID);

   always_comb begin
      meta_d      = PIN_2;
      s_d         = meta_q;
      s_dly_d     = s_q;
      state_d     = state_q;
      slot_d      = edge_det ? '0 : slot_q + 1'b1;
      silent_d    = silent_q;
      shift_d     = shift_q;
      fill_d      = fill_q;
      led_d       = led_q;
      bit_valid_d = 1'b0;
      bit_data_d  = bit_data_q;
      match_d     = 1'b0;
      match_cnt_d = match_cnt_q;

      if (state_q == HUNT) begin
         silent_d = '0;
         if (edge_det) begin
            state_d = TRACK;
         end
      end else begin
         if (edge_det) begin
            silent_d = '0;
         end else if (slot_wrap) begin
            if (silent_q == SILENT_LAST) begin
               state_d  = HUNT;
               silent_d = '0;
               shift_d  = '0;
               fill_d   = '0;
               led_d    = 1'b0;
            end else begin
               silent_d = silent_q + 1'b1;
            end
         end

         if (sample_pt) begin
            shift_d     = {s_q, shift_q[31:1]};
            bit_valid_d = 1'b1;
            bit_data_d  = s_q;
            if (fill_q != FILL_FULL) begin
               fill_d = fill_q + 1'b1;
            end
            if (fill_d == FILL_FULL) begin
               if (shift_d == PATTERN) begin
                  match_d = 1'b1;
                  led_d   = 1'b1;
                  if (match_cnt_q != 8'hFF) begin
                     match_cnt_d = match_cnt_q + 1'b1;
                  end
               end else begin
                  led_d = 1'b0;
               end
            end
         end
      end

      // Lock shows one cycle after acquisition and drops with the timeout itself.
      locked_d = (state_q == TRACK) && (state_d == TRACK);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= HUNT;
         meta_q      <= 1'b0;
         s_q         <= 1'b0;
         s_dly_q     <= 1'b0;
         slot_q      <= '0;
         silent_q    <= '0;
         shift_q     <= '0;
         fill_q      <= '0;
         locked_q    <= 1'b0;
         led_q       <= 1'b0;
         bit_valid_q <= 1'b0;
         bit_data_q  <= 1'b0;
         match_q     <= 1'b0;
         match_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         meta_q      <= meta_d;
         s_q         <= s_d;
         s_dly_q     <= s_dly_d;
         slot_q      <= slot_d;
         silent_q    <= silent_d;
         shift_q     <= shift_d;
         fill_q      <= fill_d;
         locked_q    <= locked_d;
         led_q       <= led_d;
         bit_valid_q <= bit_valid_d;
         bit_data_q  <= bit_data_d;
         match_q     <= match_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign LED       = led_q;
   assign LOCKED    = locked_q;
   assign BIT_VALID = bit_valid_q;
   assign BIT_DATA  = bit_data_q;
   assign MATCH     = match_q;
   assign MATCH_CNT = match_cnt_q;
   assign USBPU     = 1'b0;

endmodule

// File: doc/pattern_rx.md
Name: pattern_rx

Overview:
- Receiving end of the slotted on/off blink-pattern link. The peer transmitter drives one pattern bit per slot of 2^SLOT_LOG2 clocks, bit 0 first, and repeats the 32-bit pattern continuously.
- This block samples a board input pin, recovers slot timing from input edges, and shifts in the received bits.
- It flags every 32-slot window that equals PATTERN, and reports lock/match status on the user LED.

Parameters:
- SLOT_LOG2, 21, log2 of clocks per bit slot (21 = 131 ms at 16 MHz; benches use 3).
- PATTERN, 32'h05477715, expected 32-bit word; bit 0 is received first.
- TIMEOUT_SLOTS, 16, consecutive edge-free slots that drop lock.

Ports:
- CLK  in  1  16 MHz clock.
- RST  in  1  synchronous, active-high reset.
- PIN_2  in  1  asynchronous serial pattern input.
- LED  out  1  high while locked and the most recent 32-bit compare matched.
- LOCKED  out  1  slot timing acquired.
- BIT_VALID  out  1  one-cycle strobe, a slot sample was taken.
- BIT_DATA  out  1  sampled bit value, valid with BIT_VALID.
- MATCH  out  1  one-cycle strobe, the 32-bit window equals PATTERN.
- MATCH_CNT  out  8  saturating count of MATCH strobes.
- USBPU  out  1  tied 0 (USB pull-up disabled).

Behaviour:
- Reset: all outputs 0, state HUNT, shift register 0, fill count 0, slot counter 0, silent-slot counter 0.
- Synchroniser: PIN_2 passes through 2 flops to give s. An edge is detected when s differs from s delayed one more flop. Edge-to-detect latency is 3 clocks.
- Slot counter: SLOT_LOG2 bits.
  - Counts 0..2^SLOT_LOG2-1 and wraps.
  - Any detected edge forces it to 0 that cycle; the edge wins over the wrap.
- HUNT state:
  - No sampling.
  - First detected edge: counter set to 0, silent-slot counter set to 0, go to TRACK.
  - LOCKED goes 1 on the next cycle.
- TRACK state:
  - Sample point: counter == 2^(SLOT_LOG2-1) with no edge that cycle.
    - Shift the sampled s in at bit 31 (shift right); the oldest bit sits at bit 0.
    - Assert BIT_VALID and BIT_DATA on the next cycle (registered).
  - Fill count: increments per sample and saturates at 32.
  - Compare: each sample with fill == 32 after the shift compares the new window against PATTERN.
    - Equal: MATCH pulses on the same cycle as BIT_VALID. MATCH_CNT increments, saturating at 255. LED is set.
    - Unequal: LED is cleared.
    - While fill < 32: no compare, LED stays 0.
  - Silent-slot counter:
    - Increments on each counter wrap that has no edge; clears on any edge.
    - Reaching TIMEOUT_SLOTS: go to HUNT. LOCKED, LED, shift register and fill count are cleared. MATCH_CNT is retained.
- Edge coinciding with the sample point: the edge takes precedence. Counter goes to 0, no sample is taken that cycle, and the slot is sampled at the next midpoint.
- Slot-length jitter up to ±2^(SLOT_LOG2-2) clocks is tolerated, because every edge re-centres the counter.
- RST mid-frame: next cycle matches the reset state exactly. Any pending BIT_VALID or MATCH strobe is suppressed.

Test Plan (SLOT_LOG2=3, 8-clock slots):
- Drive PATTERN bit 0 first, 8 clocks/bit, two full repetitions after 4 idle-low slots.
  - LOCKED rises 4 clocks after the first rising input edge.
  - 64 BIT_VALID strobes with BIT_DATA following the pattern.
  - MATCH pulses exactly at the 32nd sample of each aligned repetition.
  - MATCH_CNT=1 after the first, 2 after the second; LED=1.
- Third repetition with bit 5 inverted.
  - No MATCH at that window; LED falls at the first compare after the corrupt bit enters.
  - Fourth clean repetition gives MATCH; MATCH_CNT=3; LED=1.
- Hold PIN_2 low for 16 slots after lock.
  - LOCKED and LED drop to 0 at the 16th silent wrap; MATCH_CNT unchanged.
  - Resumed pattern re-locks and matches after 32 new samples.
- Slots alternating 7 and 9 clocks with the correct pattern: same MATCH/BIT_DATA sequence as the nominal run, no missed or duplicate samples.
- Assert RST for 1 cycle mid-repetition.
  - All outputs 0 the next cycle; state HUNT; MATCH_CNT=0.
  - Relock on the next edge.
- Force 260 matching repetitions: MATCH_CNT saturates at 255 and does not wrap to 0.
